// File: rtl/router_merge_arbiter.sv
// router_merge_arbiter
// Merges two upstream request/ready channels that target the same
// destination FIFO. Round-robin arbitration with a bounded burst lock. Each
// accepted word has its route bit replaced by the source port number and is
// parked in a one-word output register. The register is drained into the FIFO
// whenever the FIFO is not full.
//
// Ports:
//   clk, reset_n      clock; asynchronous active-low reset
//   req_0/data_0      input 0 request and word; ready_0 accepts it
//   req_1/data_1      input 1 request and word; ready_1 accepts it
//   full              destination FIFO full flag
//   write, data_out   destination FIFO write strobe and word
module router_merge_arbiter #(
    parameter int DATA_W    = 11,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_0,
    input  logic [DATA_W-1:0] data_0,
    output logic              ready_0,
    input  logic              req_1,
    input  logic [DATA_W-1:0] data_1,
    output logic              ready_1,
    input  logic              full,
    output logic              write,
    output logic [DATA_W-1:0] data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [8:0]        BURST_LAST   = 9'(MAX_BURST);
    localparam logic [DATA_W-1:0] PAYLOAD_MASK = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] ROUTE_BIT    = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;
    logic              last_served_q, last_served_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic   can_accept_s;
    logic   write_s;
    logic   xfer_0_s;
    logic   xfer_1_s;
    logic   cur_src_s;
    logic   cur_req_s;
    logic   oth_req_s;
    logic   cur_xfer_s;
    logic   burst_done_s;
    state_t grant_oth_s;

    // Handshake strobes: readies follow the registered grant, gated by room in the output register.
    always_comb begin
        write_s      = out_valid_q && !full;
        can_accept_s = !out_valid_q || !full;
        ready_0      = (state_q == GRANT0) && can_accept_s;
        ready_1      = (state_q == GRANT1) && can_accept_s;
        xfer_0_s     = req_0 && ready_0;
        xfer_1_s     = req_1 && ready_1;
        // View of the arbiter from the currently granted input's side.
        cur_src_s    = (state_q == GRANT1);
        cur_req_s    = cur_src_s ? req_1 : req_0;
        oth_req_s    = cur_src_s ? req_0 : req_1;
        cur_xfer_s   = xfer_0_s || xfer_1_s;
        grant_oth_s  = cur_src_s ? GRANT0 : GRANT1;
        burst_done_s = (({1'b0, burst_cnt_q} + 9'd1) == BURST_LAST);
    end

    // Grant FSM next state, burst counter and round-robin pointer.
    always_comb begin
        state_d       = state_q;
        burst_cnt_d   = burst_cnt_q;
        last_served_d = last_served_q;
        case (state_q)
            IDLE: begin
                if (req_0 && req_1) begin
                    // Tie goes to the input that was not served last.
                    state_d     = last_served_q ? GRANT0 : GRANT1;
                    burst_cnt_d = 8'd0;
                end else if (req_0) begin
                    state_d     = GRANT0;
                    burst_cnt_d = 8'd0;
                end else if (req_1) begin
                    state_d     = GRANT1;
                    burst_cnt_d = 8'd0;
                end else begin
                    state_d     = IDLE;
                end
            end
            GRANT0, GRANT1: begin
                if (cur_xfer_s) begin
                    burst_cnt_d   = burst_cnt_q + 8'd1;
                    last_served_d = cur_src_s;
                end else begin
                    burst_cnt_d   = burst_cnt_q;
                end
                // Release beats burst expiry; a dropped request never transfers.
                if (!cur_req_s) begin
                    state_d     = oth_req_s ? grant_oth_s : IDLE;
                    burst_cnt_d = 8'd0;
                end else if (cur_xfer_s && burst_done_s) begin
                    // Burst window ends; hand over only if the other side waits.
                    state_d     = oth_req_s ? grant_oth_s : state_q;
                    burst_cnt_d = 8'd0;
                end else begin
                    state_d     = state_q;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = 8'd0;
            end
        endcase
    end

    // Output register: load a stamped word on transfer, else drop it once written.
    always_comb begin
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        if (xfer_0_s) begin
            data_out_d  = data_0 & PAYLOAD_MASK;
            out_valid_d = 1'b1;
        end else if (xfer_1_s) begin
            data_out_d  = (data_1 & PAYLOAD_MASK) | ROUTE_BIT;
            out_valid_d = 1'b1;
        end else if (write_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous reset; a parked word is discarded on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            burst_cnt_q   <= 8'd0;
            last_served_q <= 1'b1;
            data_out_q    <= {DATA_W{1'b0}};
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            burst_cnt_q   <= burst_cnt_d;
            last_served_q <= last_served_d;
            data_out_q    <= data_out_d;
        end
    end

    assign write    = write_s;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_router_merge_arbiter.sv
module tb_router_merge_arbiter;
    localparam int DATA_W    = 11;
    localparam int MAX_BURST = 4;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_0   = 1'b0;
    logic              req_1   = 1'b0;
    logic              full    = 1'b0;
    logic [DATA_W-1:0] data_0  = '0;
    logic [DATA_W-1:0] data_1  = '0;
    logic              ready_0, ready_1, write;
    logic [DATA_W-1:0] data_out;

    int total = 0;
    int bad   = 0;

    // Scoreboard: words accepted from upstream, in order, not yet written.
    logic [DATA_W-1:0] exp_q[$];

    // Per-cycle observations taken by step().
    int x0, x1, r0, r1, wr;
    logic [DATA_W-1:0] dout;

    // Burst bound bookkeeping: consecutive transfers of run_src while the other side requested.
    int run_src = -1;
    int run_len = 0;

    router_merge_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_0(req_0), .data_0(data_0), .ready_0(ready_0),
        .req_1(req_1), .data_1(data_1), .ready_1(ready_1),
        .full(full), .write(write), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic note_burst(input int s, input logic other_req);
        if (!other_req) begin
            run_len = 0;
        end else begin
            if (run_src == s) run_len++;
            else begin
                run_src = s;
                run_len = 1;
            end
            check("burst_bound", (run_len <= MAX_BURST) ? 1 : 0, 1);
        end
    endtask

    // One clock cycle: observe handshakes at the falling edge, push accepted
    // words into the scoreboard, return 1 time unit after the next rising edge.
    task automatic step();
        @(negedge clk);
        x0   = (req_0 && ready_0) ? 1 : 0;
        x1   = (req_1 && ready_1) ? 1 : 0;
        r0   = ready_0 ? 1 : 0;
        r1   = ready_1 ? 1 : 0;
        wr   = write ? 1 : 0;
        dout = data_out;
        if (x0 == 1) begin
            exp_q.push_back({1'b0, data_0[DATA_W-2:0]});
            note_burst(0, req_1);
        end
        if (x1 == 1) begin
            exp_q.push_back({1'b1, data_1[DATA_W-2:0]});
            note_burst(1, req_0);
        end
        @(posedge clk);
        #1;
    endtask

    // Both inputs request continuously; the source order must alternate in bursts.
    task automatic both_stream(input int n, input int first);
        req_0 = 1'b1;
        req_1 = 1'b1;
        step();
        check("tie_bubble", x0 + x1, 0);
        for (int k = 0; k < n; k++) begin
            step();
            check("stream_one_xfer", x0 + x1, 1);
            check("stream_src", x1, first ^ ((k / MAX_BURST) % 2));
            if (x0 == 1) data_0 = data_0 + 11'd1;
            if (x1 == 1) data_1 = data_1 + 11'd1;
        end
        req_0 = 1'b0;
        req_1 = 1'b0;
        step();
        step();
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes, checks FIFO-side rules.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (reset_n) begin
                if (exp_q.size() > 0 && !full) check("write", {31'd0, write}, 1);
                else check("write", {31'd0, write}, 0);
                if (write && exp_q.size() > 0) check("data_out", {21'd0, data_out}, {21'd0, exp_q.pop_front()});
                check("ready_excl", {31'd0, ready_0 & ready_1}, 0);
                if (exp_q.size() > 0 && full) check("ready_when_full", {31'd0, ready_0 | ready_1}, 0);
            end
        end
    end

    initial begin
        int guard;
        logic [DATA_W-1:0] exp_w;

        // Reset state
        #12;
        check("rst_ready_0", {31'd0, ready_0}, 0);
        check("rst_ready_1", {31'd0, ready_1}, 0);
        check("rst_write", {31'd0, write}, 0);
        check("rst_data_out", {21'd0, data_out}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single source stream from input 0
        req_0  = 1'b1;
        data_0 = 11'h7FD;
        step();
        check("t1_bubble", x0, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            check("t1_xfer", x0, 1);
            check("t1_ready_1", r1, 0);
            if (k > 0) begin
                exp_w = (11'h7FD + 11'(k - 1)) & 11'h3FF;
                check("t1_write", wr, 1);
                check("t1_data_out", {21'd0, dout}, {21'd0, exp_w});
            end
            if (x0 == 1) data_0 = data_0 + 11'd1;
        end
        req_0 = 1'b0;
        step();
        step();

        // Input 0 was served last, so a simultaneous request goes to input 1
        data_0 = 11'h100;
        data_1 = 11'h200;
        both_stream(10, 1);

        // Backpressure on an input 1 stream
        req_1  = 1'b1;
        data_1 = 11'h403;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_xfer", x1, 1);
            if (x1 == 1) data_1 = data_1 + 11'd1;
        end
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_frozen", {21'd0, dout}, 32'h405);
            check("t3_no_write", wr, 0);
            check("t3_no_ready", r1, 0);
        end
        full = 1'b0;
        step();
        check("t3_resume_write", wr, 1);
        check("t3_resume_ready", r1, 1);
        check("t3_resume_xfer", x1, 1);
        if (x1 == 1) data_1 = data_1 + 11'd1;
        step();
        check("t3_next_word", {21'd0, dout}, 32'h406);
        req_1 = 1'b0;
        step();
        step();

        // Grant release: input 0 gives up after two words while input 1 waits
        req_0 = 1'b1;
        req_1 = 1'b1;
        step();
        step();
        check("t4_g0_a", x0, 1);
        data_0 = data_0 + 11'd1;
        step();
        check("t4_g0_b", x0, 1);
        data_0 = data_0 + 11'd1;
        req_0 = 1'b0;
        step();
        check("t4_gap", x0 + x1, 0);
        req_0 = 1'b1;
        for (int k = 0; k < MAX_BURST; k++) begin
            step();
            check("t4_g1_burst", x1, 1);
            if (x1 == 1) data_1 = data_1 + 11'd1;
        end
        step();
        check("t4_back_to_0", x0, 1);
        req_0 = 1'b0;
        step();
        req_1 = 1'b0;
        step();
        step();
        check("t4_idle_r0", r0, 0);
        check("t4_idle_r1", r1, 0);

        // Reset while a word is parked and the FIFO is full
        req_0 = 1'b1;
        step();
        step();
        check("t5_xfer", x0, 1);
        req_0 = 1'b0;
        full  = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_write", {31'd0, write}, 0);
        check("t5_ready_0", {31'd0, ready_0}, 0);
        check("t5_ready_1", {31'd0, ready_1}, 0);
        check("t5_data_out", {21'd0, data_out}, 0);
        exp_q.delete();
        run_len = 0;
        #29;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        full = 1'b0;
        both_stream(10, 0);

        // Randomized traffic; a request is held until it is accepted
        for (int c = 0; c < 400; c++) begin
            step();
            if (x0 == 1 || !req_0) begin
                req_0  = ($urandom_range(0, 99) < 65);
                data_0 = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            end
            if (x1 == 1 || !req_1) begin
                req_1  = ($urandom_range(0, 99) < 65);
                data_1 = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            end
            full = ($urandom_range(0, 99) < 25);
        end

        // Drain outstanding requests and the output register
        full  = 1'b0;
        guard = 0;
        while ((req_0 || req_1 || exp_q.size() > 0) && guard < 60) begin
            step();
            if (x0 == 1) req_0 = 1'b0;
            if (x1 == 1) req_1 = 1'b0;
            guard++;
        end
        check("drain_in_time", (guard < 60) ? 1 : 0, 1);
        check("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
